seq_mul_param: RTL and testbench



---
 rtl/mul_pkg.sv | 28 ++
 rtl/seq_mul_param_if.sv | 19 +
 rtl/mul_pp_step.sv | 21 ++
 rtl/seq_mul_param.sv | 118 +++++++++++
 tb/tb_seq_mul_param.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Operand width is limited to MAX_W bits by the abs_w helper.
package mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_e;

  localparam int MAX_W              = 64;
  localparam int DEF_WIDTH          = 32;
  localparam int DEF_BITS_PER_CYCLE = 1;

  function automatic int cnt_w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N     = DEF_WIDTH / DEF_BITS_PER_CYCLE;
  localparam int CNT_W = cnt_w_of(N);

  // Magnitude of a w-bit value; -2^(w-1) maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x,
                                             input int unsigned      w,
                                             input logic             signed_op);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    if (signed_op && x[w-1]) return (~x + MAX_W'(1)) & mask;
    return x & mask;
  endfunction

endpackage

// File: rtl/seq_mul_param_if.sv
// Request/response bundle between the operand mux, the multiplier and writeback.
interface seq_mul_param_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             busy;

  modport master (output in_valid, a, b, signed_op, out_ready,
                  input  in_ready, out_valid, res_lo, res_hi, busy);

  modport slave  (input  in_valid, a, b, signed_op, out_ready,
                  output in_ready, out_valid, res_lo, res_hi, busy);
endinterface

// File: rtl/mul_pp_step.sv
// One partial product per cycle: mcand times a BITS_PER_CYCLE-bit multiplier digit,
// aligned to the digit's position in the multiplier.
module mul_pp_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int CNT_W          = 5
) (
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  input  logic [CNT_W-1:0]          cnt,
  output logic [2*WIDTH-1:0]        pp
);

  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod = (2*WIDTH)'(mcand) * (2*WIDTH)'(digit);
    pp   = prod << (32'(cnt) * BITS_PER_CYCLE);
  end

endmodule

// File: rtl/seq_mul_param.sv
// Iterative sign-magnitude shift-add multiplier with a full 2*WIDTH product and
// valid/ready handshakes on both sides; one operation in flight.
module seq_mul_param
  import mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst,
  seq_mul_param_if.slave bus
);

  localparam int                STEPS  = WIDTH / BITS_PER_CYCLE;
  localparam int                STEP_W = cnt_w_of(STEPS);
  localparam logic [STEP_W-1:0] LAST   = STEP_W'(STEPS - 1);

  mul_state_e                state_q, state_d;
  logic [STEP_W-1:0]         cnt_q;
  logic [WIDTH-1:0]          mcand_q, mplier_q;
  logic                      neg_q;
  logic [2*WIDTH-1:0]        acc_q, acc_sum, pp, product;
  logic [WIDTH-1:0]          res_lo_q, res_hi_q;
  logic [WIDTH-1:0]          a_abs, b_abs;
  logic [BITS_PER_CYCLE-1:0] digit;
  logic                      accept, finish;

  assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;

  assign a_abs = WIDTH'(abs_w(MAX_W'(bus.a), WIDTH, bus.signed_op));
  assign b_abs = WIDTH'(abs_w(MAX_W'(bus.b), WIDTH, bus.signed_op));
  assign digit = mplier_q[32'(cnt_q) * BITS_PER_CYCLE +: BITS_PER_CYCLE];

  mul_pp_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CNT_W          (STEP_W)
  ) u_pp_step (
    .mcand (mcand_q),
    .digit (digit),
    .cnt   (cnt_q),
    .pp    (pp)
  );

  assign acc_sum = acc_q + pp;
  assign product = neg_q ? -acc_sum : acc_sum;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Handshake and a new request on the same edge go straight back to RUN.
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: datapath registers are reset too, so an abandoned operation can never leak into res_*.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else if (accept) begin
      mcand_q  <= a_abs;
      mplier_q <= b_abs;
      neg_q    <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_sum;
      if (finish) begin
        res_lo_q <= product[WIDTH-1:0];
        res_hi_q <= product[2*WIDTH-1:WIDTH];
      end else begin
        cnt_q <= cnt_q + STEP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_param.sv
// Bench for seq_mul_param: a W=32/K=1 and a W=16/K=4 instance, each shadowed by a
// cycle-level arithmetic model, plus directed operations with literal products.
module tb_seq_mul_param;

  typedef struct {
    bit           busy;
    int           left;
    logic [127:0] prod;
    logic [127:0] last;
  } model_t;

  logic   clk = 1'b0;
  logic   rst;
  int     tests = 0;
  int     fails = 0;
  model_t m32, m32_n, m16, m16_n;

  always #5 clk = ~clk;

  seq_mul_param_if #(.WIDTH(32)) bus32 ();
  seq_mul_param_if #(.WIDTH(16)) bus16 ();

  seq_mul_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  seq_mul_param #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Exact product of two w-bit operands, truncated to 2w bits.
  function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                            input int w, input bit s);
    logic [127:0] m, ae, be;
    m  = (128'(1) << w) - 128'(1);
    ae = 128'(a) & m;
    be = 128'(b) & m;
    if (s && a[w-1]) ae = ae | ~m;
    if (s && b[w-1]) be = be | ~m;
    return (ae * be) & ((128'(1) << (2 * w)) - 128'(1));
  endfunction

  // Compares one DUT against its model, then predicts the state after the next edge.
  task automatic model_step(input string tag, input int w, input int n, input logic rst_v,
                            input logic iv, input logic [63:0] a, input logic [63:0] b,
                            input logic s, input logic ordy, input logic ir, input logic ov,
                            input logic bsy, input logic [63:0] lo, input logic [63:0] hi,
                            input model_t mi, output model_t mo);
    logic [127:0] got;
    bit           ev, eir;
    mo  = mi;
    got = (128'(hi) << w) | 128'(lo);
    if (!rst_v) begin
      check({tag, " reset out_valid"}, 128'(ov), 128'(0));
      check({tag, " reset busy"}, 128'(bsy), 128'(0));
      check({tag, " reset res"}, got, 128'(0));
      mo.busy = 1'b0;
      mo.left = 0;
      mo.prod = '0;
      mo.last = '0;
    end else begin
      ev  = mi.busy && (mi.left == 0);
      eir = !mi.busy || (ev && ordy);
      check({tag, " out_valid"}, 128'(ov), 128'(ev));
      check({tag, " busy"}, 128'(bsy), 128'(mi.busy));
      check({tag, " in_ready"}, 128'(ir), 128'(eir));
      check({tag, " res"}, got, mi.last);
      if (ev && ordy) begin
        mo.busy = 1'b0;
      end else if (mi.busy && mi.left > 0) begin
        mo.left = mi.left - 1;
        if (mo.left == 0) mo.last = mi.prod;
      end
      if (iv && eir) begin
        mo.busy = 1'b1;
        mo.left = n;
        mo.prod = ref_prod(a, b, w, s);
      end
    end
  endtask

  always @(negedge clk) begin
    model_step("dut32", 32, 32, rst, bus32.in_valid, 64'(bus32.a), 64'(bus32.b),
               bus32.signed_op, bus32.out_ready, bus32.in_ready, bus32.out_valid, bus32.busy,
               64'(bus32.res_lo), 64'(bus32.res_hi), m32, m32_n);
    m32 = m32_n;
  end

  always @(negedge clk) begin
    model_step("dut16", 16, 4, rst, bus16.in_valid, 64'(bus16.a), 64'(bus16.b),
               bus16.signed_op, bus16.out_ready, bus16.in_ready, bus16.out_valid, bus16.busy,
               64'(bus16.res_lo), 64'(bus16.res_hi), m16, m16_n);
    m16 = m16_n;
  end

  task automatic drive(input int id, input bit iv, input logic [63:0] a, input logic [63:0] b,
                       input bit s, input bit ordy);
    if (id == 32) begin
      bus32.in_valid  = iv;
      bus32.a         = a[31:0];
      bus32.b         = b[31:0];
      bus32.signed_op = s;
      bus32.out_ready = ordy;
    end else begin
      bus16.in_valid  = iv;
      bus16.a         = a[15:0];
      bus16.b         = b[15:0];
      bus16.signed_op = s;
      bus16.out_ready = ordy;
    end
  endtask

  task automatic get(input int id, output bit ov, output bit ir, output bit bsy,
                     output logic [63:0] res);
    if (id == 32) begin
      ov  = bus32.out_valid;
      ir  = bus32.in_ready;
      bsy = bus32.busy;
      res = {bus32.res_hi, bus32.res_lo};
    end else begin
      ov  = bus16.out_valid;
      ir  = bus16.in_ready;
      bsy = bus16.busy;
      res = {32'd0, bus16.res_hi, bus16.res_lo};
    end
  endtask

  // Counts edges after the accept edge until out_valid, bounded by a cycle budget.
  task automatic wait_valid(input string name, input int id, input int n, input logic [63:0] exp);
    bit          ov, ir, bsy;
    logic [63:0] res;
    int          cyc;
    cyc = 0;
    get(id, ov, ir, bsy, res);
    while (!ov && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      get(id, ov, ir, bsy, res);
    end
    check({name, " latency"}, 128'(cyc), 128'(n));
    check({name, " product"}, 128'(res), 128'(exp));
  endtask

  // Issues one operation, waits for its result and leaves it un-acknowledged in DONE.
  task automatic run_op(input string name, input int id, input int n, input logic [63:0] a,
                        input logic [63:0] b, input bit s, input logic [63:0] exp);
    @(posedge clk);
    #1;
    drive(id, 1'b1, a, b, s, 1'b0);
    @(posedge clk);
    #1;
    drive(id, 1'b0, '0, '0, 1'b0, 1'b0);
    wait_valid(name, id, n, exp);
  endtask

  task automatic ack(input int id);
    drive(id, 1'b0, '0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(id, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit          ov, ir, bsy;
    logic [63:0] res;
    rst = 1'b0;
    drive(32, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(16, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    get(32, ov, ir, bsy, res);
    check("post-reset in_ready dut32", 128'(ir), 128'(1));
    get(16, ov, ir, bsy, res);
    check("post-reset in_ready dut16", 128'(ir), 128'(1));

    run_op("s32 -7*6", 32, 32, 64'hFFFF_FFF9, 64'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);
    ack(32);
    run_op("u32 max*max", 32, 32, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    ack(32);
    run_op("s32 min*min", 32, 32, 64'h8000_0000, 64'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    ack(32);
    run_op("s32 -1*1", 32, 32, 64'hFFFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    ack(32);
    run_op("u32 zero", 32, 32, 64'd0, 64'h1234_5678, 1'b0, 64'd0);
    ack(32);

    run_op("u16 300*200", 16, 4, 64'd300, 64'd200, 1'b0, 64'h0000_EA60);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      get(16, ov, ir, bsy, res);
      check($sformatf("hold%0d res", i), 128'(res), 128'(64'h0000_EA60));
      check($sformatf("hold%0d in_ready", i), 128'(ir), 128'(0));
      check($sformatf("hold%0d out_valid", i), 128'(ov), 128'(1));
    end
    ack(16);
    run_op("s16 -300*200", 16, 4, 64'hFED4, 64'd200, 1'b1, 64'hFFFF_15A0);
    ack(16);
    run_op("s16 min*min", 16, 4, 64'h8000, 64'h8000, 1'b1, 64'h4000_0000);
    ack(16);

    // Back-to-back: acknowledge and issue on the same edge.
    run_op("b2b first", 32, 32, 64'd3, 64'd7, 1'b0, 64'd21);
    drive(32, 1'b1, 64'd1000, 64'hFFFF_FFFD, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    drive(32, 1'b0, '0, '0, 1'b0, 1'b0);
    wait_valid("b2b second", 32, 32, 64'hFFFF_FFFF_FFFF_F448);
    ack(32);

    // Reset in the middle of an operation, at cnt=10.
    @(posedge clk);
    #1;
    drive(32, 1'b1, 64'h1234, 64'h5678, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(32, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    get(32, ov, ir, bsy, res);
    check("mid-op reset out_valid", 128'(ov), 128'(0));
    check("mid-op reset busy", 128'(bsy), 128'(0));
    check("mid-op reset res", 128'(res), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_op("after reset 3*5", 32, 32, 64'd3, 64'd5, 1'b0, 64'd15);
    ack(32);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
